// File: rtl/pipe_share_arbiter_pkg.sv
// Shared types and constants for the pipeline-sharing round-robin scheduler.
package pipe_share_pkg;

    // Default parameter values used by the interface and the modules.
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LATENCY = 3;
    localparam int DEF_MAX_OUT = 2;

    // Stored tag id width; wide enough for up to 256 requesters.
    localparam int TAG_ID_W = 8;

    // Requester index width: clog2 with a floor of one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // One in-flight slot of the tag shift register.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/pipe_share_arbiter_if.sv
// Requester, pipeline and response signals of the shared-pipeline scheduler.
interface pipe_share_arbiter_if
    import pipe_share_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    logic                      hold;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          req_ready;
    logic                      pipe_valid;
    logic [DATA_W-1:0]         pipe_data;
    logic [DATA_W-1:0]         pipe_out;
    logic [N_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    // Requesters and the shared pipeline's result side.
    modport master (
        output hold, req_valid, req_data, pipe_out,
        input  req_ready, pipe_valid, pipe_data, rsp_valid, rsp_data, busy
    );

    // The scheduler.
    modport slave (
        input  hold, req_valid, req_data, pipe_out,
        output req_ready, pipe_valid, pipe_data, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/pipe_share_arbiter_rr.sv
// Combinational round-robin pick: first eligible index above ptr, wrapping.
module rr_arbiter
    import pipe_share_pkg::*;
#(
    parameter int  N_REQ = DEF_N_REQ,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // Scan ptr+1, ptr+2, ... modulo N_REQ and take the first eligible slot.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency, non-stalling pipeline between N_REQ requesters:
// round-robin issue, per-requester credit limit, tag tracking and result steering.
module pipe_share_arbiter
    import pipe_share_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input logic                  clk,
    input logic                  rst,
    pipe_share_arbiter_if.slave  bus
);

    localparam int              ID_W    = id_width(N_REQ);
    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt [N_REQ];
    tag_t              tags [LATENCY];

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gnt_idx;
    logic [N_REQ-1:0]  rsp_hit;
    logic [DATA_W-1:0] data_mux;
    logic              busy_c;
    tag_t              last_tag;

    // Eligible = requesting, under credit limit, not held, not in reset.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = rst & ~bus.hold & bus.req_valid[i] & (cnt[i] < CNT_MAX);
        end
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (gnt_idx)
    );

    assign bus.req_ready  = grant;
    assign bus.pipe_valid = |grant;

    // Forward the granted requester's data; zero when nothing is issued.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) data_mux = bus.req_data[i*DATA_W +: DATA_W];
        end
    end
    assign bus.pipe_data = data_mux;

    // Round-robin pointer remembers the last winner; reset makes requester 0 win first.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst)          ptr <= ID_W'(N_REQ - 1);
        else if (|grant)   ptr <= gnt_idx;
    end

    // Tag shift register tracks who owns each pipeline stage; it never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the tag array is reset because its valid bits gate responses; stale tags must never fire.
            for (int k = 0; k < LATENCY; k++) tags[k] <= '0;
        end else begin
            tags[0] <= '{valid: bus.pipe_valid, id: TAG_ID_W'(gnt_idx)};
            for (int k = 1; k < LATENCY; k++) tags[k] <= tags[k-1];
        end
    end

    assign last_tag = tags[LATENCY-1];

    // Decode the emerging tag into a one-hot response strobe.
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_hit[i] = last_tag.valid && (last_tag.id == TAG_ID_W'(i));
        end
    end

    assign bus.rsp_valid = rsp_hit;
    assign bus.rsp_data  = bus.pipe_out;

    // Busy while any stage carries a tagged item.
    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < LATENCY; k++) busy_c = busy_c | tags[k].valid;
    end
    assign bus.busy = busy_c;

    // Outstanding credit per requester: +1 on issue, -1 on result, both cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({grant[i], rsp_hit[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Reference count of in-flight tags per requester, for the invariant checks.
    int tag_cnt [N_REQ];
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            tag_cnt[i] = 0;
            for (int k = 0; k < LATENCY; k++) begin
                if (tags[k].valid && tags[k].id == TAG_ID_W'(i)) tag_cnt[i] = tag_cnt[i] + 1;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.req_ready));
    a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.rsp_valid));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_inv
        a_cnt_match: assert property (@(posedge clk) disable iff (!rst) int'(cnt[gi]) == tag_cnt[gi]);
        a_cnt_over:  assert property (@(posedge clk) disable iff (!rst) cnt[gi] <= CNT_MAX);
        a_cnt_under: assert property (@(posedge clk) disable iff (!rst) rsp_hit[gi] |-> cnt[gi] != '0);
    end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter: a queue-based model of issue/response behaviour
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_pipe_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 3;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_share_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    pipe_share_arbiter #(.N_REQ(N), .DATA_W(W), .LATENCY(L), .MAX_OUT(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Pipeline function used by the shared pipeline model.
    function automatic logic [W-1:0] pipe_f(input logic [W-1:0] x);
        return ~x;
    endfunction

    // Requester data, packed onto the bus.
    logic [W-1:0] req_d [N];
    assign bus.req_data = {req_d[3], req_d[2], req_d[1], req_d[0]};

    // Shared pipeline model: L stages, data registers only load when valid.
    logic         pv [L];
    logic [W-1:0] pd [L];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < L; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= bus.pipe_valid;
            if (bus.pipe_valid) pd[0] <= pipe_f(bus.pipe_data);
            for (int k = 1; k < L; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) pd[k] <= pd[k-1];
            end
        end
    end
    assign bus.pipe_out = pd[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: list of issued items, each responding exactly L cycles later.
    typedef struct {
        int           c;
        logic [1:0]   id;
        logic [W-1:0] d;
    } item_t;

    item_t        q [$];
    int           last_id = N - 1;
    int           m_out [N];
    int           m_gid;
    logic [1:0]   m_j;
    logic [N-1:0] m_ready, m_rsp;
    logic [W-1:0] m_pd, m_rd;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            last_id = N - 1;
            check("rst_req_ready",  bus.req_ready,  0);
            check("rst_pipe_valid", bus.pipe_valid, 0);
            check("rst_pipe_data",  bus.pipe_data,  0);
            check("rst_rsp_valid",  bus.rsp_valid,  0);
            check("rst_busy",       bus.busy,       0);
        end else begin
            while (q.size() > 0 && q[0].c + L < cyc) void'(q.pop_front());
            for (int i = 0; i < N; i++) m_out[i] = 0;
            foreach (q[j]) m_out[q[j].id] = m_out[q[j].id] + 1;
            m_gid = -1;
            if (!bus.hold) begin
                for (int k = 1; k <= N; k++) begin
                    m_j = 2'((last_id + k) % N);
                    if (m_gid < 0 && bus.req_valid[m_j] && m_out[m_j] < M) m_gid = int'(m_j);
                end
            end
            m_ready = '0;
            m_pd    = '0;
            if (m_gid >= 0) begin
                m_ready[2'(m_gid)] = 1'b1;
                m_pd               = req_d[2'(m_gid)];
            end
            m_rsp = '0;
            m_rd  = '0;
            if (q.size() > 0 && q[0].c + L == cyc) begin
                m_rsp[q[0].id] = 1'b1;
                m_rd           = pipe_f(q[0].d);
            end
            check("req_ready",  bus.req_ready,  m_ready);
            check("pipe_valid", bus.pipe_valid, (m_gid >= 0));
            check("pipe_data",  bus.pipe_data,  m_pd);
            check("rsp_valid",  bus.rsp_valid,  m_rsp);
            check("busy",       bus.busy,       (q.size() > 0));
            if (m_rsp != '0) check("rsp_data", bus.rsp_data, m_rd);
            if (m_gid >= 0) begin
                q.push_back('{c: cyc, id: 2'(m_gid), d: m_pd});
                last_id = m_gid;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [N-1:0] gnt_log [16];
    logic [N-1:0] rsp_log [16];
    logic [W-1:0] dat_log [16];
    logic         bsy_log [16];
    logic [1:0]   cnt_log [16];

    task automatic run_log(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            gnt_log[t] = bus.req_ready;
            rsp_log[t] = bus.rsp_valid;
            dat_log[t] = bus.rsp_data;
            bsy_log[t] = bus.busy;
            cnt_log[t] = dut.cnt[2];
            next();
        end
    endtask

    initial begin
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) req_d[i] = '0;
        #1;

        // A: everyone requesting -> strict rotation 0,1,2,3 and matching responses.
        do_reset();
        req_d[0] = 32'h1111_1111; req_d[1] = 32'h2222_2222;
        req_d[2] = 32'h3333_3333; req_d[3] = 32'h4444_4444;
        bus.req_valid = 4'b1111;
        run_log(8);
        for (int t = 0; t < 8; t++) check("A_grant_order", gnt_log[t], 4'b0001 << (t % 4));
        check("A_no_rsp_t2", rsp_log[2], 4'b0000);
        for (int t = 3; t < 8; t++) check("A_rsp_order", rsp_log[t], 4'b0001 << ((t - 3) % 4));
        check("A_rsp_data_t3", dat_log[3], 32'hEEEE_EEEE);
        check("A_rsp_data_t4", dat_log[4], 32'hDDDD_DDDD);

        // B/C: requester 2 alone -> two grants per four cycles, credit capped at 2.
        do_reset();
        bus.req_valid = 4'b0100;
        run_log(12);
        for (int t = 0; t < 12; t++)
            check("B_grant_pattern", gnt_log[t], ((t % 4) < 2) ? 4'b0100 : 4'b0000);
        check("B_rsp_t3", rsp_log[3], 4'b0100);
        check("B_no_rsp_t2", rsp_log[2], 4'b0000);
        check("C_rsp_with_grant_t4", rsp_log[4], 4'b0100);
        for (int t = 0; t < 12; t++)
            check("B_cnt2", cnt_log[t], (t == 0) ? 2'd0 : (t == 1) ? 2'd1 : ((t % 4) >= 2) ? 2'd2 : 2'd1);

        // D: hold for five cycles with all requesting; in-flight items drain.
        do_reset();
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 10; t++) begin
            bus.hold = (t >= 3 && t <= 7);
            @(negedge clk);
            gnt_log[t] = bus.req_ready;
            rsp_log[t] = bus.rsp_valid;
            bsy_log[t] = bus.busy;
            if (t >= 3 && t <= 7) begin
                check("D_hold_ready", bus.req_ready, 4'b0000);
                check("D_hold_pipe_valid", bus.pipe_valid, 1'b0);
            end
            next();
        end
        check("D_rsp_t3", rsp_log[3], 4'b0001);
        check("D_rsp_t4", rsp_log[4], 4'b0010);
        check("D_rsp_t5", rsp_log[5], 4'b0100);
        check("D_busy_t5", bsy_log[5], 1'b1);
        check("D_busy_t6", bsy_log[6], 1'b0);
        check("D_busy_t7", bsy_log[7], 1'b0);
        check("D_resume_grant", gnt_log[8], 4'b1000);
        bus.hold = 1'b0;

        // E: reset with three items in flight.
        do_reset();
        bus.req_valid = 4'b1111;
        run_log(3);
        check("E_busy_before", bus.busy, 1'b1);
        rst = 1'b0;
        #1;
        check("E_imm_ready",      bus.req_ready,  4'b0000);
        check("E_imm_pipe_valid", bus.pipe_valid, 1'b0);
        check("E_imm_pipe_data",  bus.pipe_data,  32'h0);
        check("E_imm_rsp",        bus.rsp_valid,  4'b0000);
        check("E_imm_busy",       bus.busy,       1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        run_log(6);
        for (int t = 0; t < 6; t++) check("E_no_late_rsp", rsp_log[t], 4'b0000);
        bus.req_valid = 4'b1111;
        run_log(1);
        check("E_first_grant", gnt_log[0], 4'b0001);

        // F: random requests and hold.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            bus.req_valid = 4'($urandom);
            bus.hold      = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) req_d[i] = $urandom;
            next();
        end
        bus.req_valid = '0;
        bus.hold      = 1'b0;
        repeat (L + 2) next();
        @(negedge clk);
        check("F_drain_busy", bus.busy, 1'b0);
        check("F_drain_model_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
